video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator, successor to the fixed 384x262 arcade timing block.
- Produces pixel and line counters, blanking, sync, data-enable, line/frame strobes and a frame counter from a pixel clock-enable.
- Geometry is set by parameters. Runtime signed H/V sync offsets are latched once per frame so sync never tears mid-frame.
- Sits between the core clock generator and the tilemap/sprite/palette pipeline and the video output scaler.

Parameters:
- CW, 9, counter width for hc/vc.
- H_TOTAL, 384, pixels per line (hc runs 0..H_TOTAL-1).
- H_ACTIVE, 256, visible pixels; hbl asserted for hc >= H_ACTIVE.
- HS_START, 264, nominal hsync first pixel.
- HS_END, 296, nominal hsync first non-sync pixel.
- V_TOTAL, 262, lines per frame (vc runs 0..V_TOTAL-1).
- V_ACTIVE, 224, visible lines; vbl asserted for vc >= V_ACTIVE.
- VS_START, 228, nominal vsync first line.
- VS_END, 232, nominal vsync first non-sync line.
- OFS_W, 9, width of signed offset inputs.
- SYNC_POL, 1, 1 = sync outputs active-high, 0 = active-low.
- FC_W, 8, frame counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- ce_pix  in  1  pixel clock enable; all state advances only when high.
- hs_offset  in  OFS_W  signed hsync shift in pixels.
- vs_offset  in  OFS_W  signed vsync shift in lines.
- hc  out  CW  pixel counter.
- vc  out  CW  line counter.
- hbl  out  1  horizontal blank.
- vbl  out  1  vertical blank.
- de  out  1  active video, equal to ~hbl & ~vbl.
- hsync  out  1  horizontal sync, polarity per SYNC_POL.
- vsync  out  1  vertical sync, polarity per SYNC_POL.
- line_start  out  1  one-clk pulse when hc becomes 0.
- frame_start  out  1  one-clk pulse when hc and vc both become 0.
- frame_cnt  out  FC_W  frames completed, wraps.

Behaviour:
- Reset (sync, wins over ce_pix):
  - hc=0, vc=0, frame_cnt=0.
  - hbl=0, vbl=0, de=1.
  - hsync and vsync inactive.
  - line_start=0, frame_start=0.
  - Offset shadows cleared to 0.
- Counting, only on cycles with ce_pix=1:
  - If hc==H_TOTAL-1: hc←0, and vc←vc+1, or vc←0 when vc==V_TOTAL-1.
  - Otherwise hc←hc+1.
  - No off-by-one: the line period is exactly H_TOTAL enables and the frame period is exactly H_TOTAL*V_TOTAL enables.
- Coherence: every flag is decoded from the next counter values and registered in the same cycle as hc/vc. Flags are therefore always consistent with the current hc/vc, with zero relative latency.
- Offset shadows:
  - hs_offset and vs_offset are sampled into shadow registers only on the ce_pix cycle where the counters wrap to (0,0).
  - Input changes mid-frame have no effect until the next frame.
- Effective sync window:
  - hs_s = (HS_START + hs_sh) mod H_TOTAL; hs_e = (HS_END + hs_sh) mod H_TOTAL.
  - vs_s and vs_e are computed the same way with V_TOTAL.
  - Arithmetic is done at CW+2 signed bits, with a single add/subtract-of-total correction. Offset magnitude is guaranteed < total; larger values are undefined.
- Sync active condition:
  - If s < e: active for s <= count < e.
  - If s > e (window wraps): active for count >= s or count < e.
  - If s == e: never active.
  - vsync changes on any pixel where vc changes, not aligned to hsync.
- line_start: high for exactly one clk, on the clk where hc is loaded with 0; low on all other clks, including ce_pix=0 clks.
- frame_start: high coincident with line_start when vc is also loaded with 0. frame_cnt increments on that same clk.
- When ce_pix is held low, every output holds its value; strobes are forced low.
- Reset mid-frame returns the block to (0,0) on the next clk. The first frame after reset asserts no frame_start at its origin; the first frame_start occurs at the end of that frame.

Decomposition:
- Shared package video_pkg holds:
  - the timing geometry constants for the default 6 MHz set;
  - a timing_t struct (hc, vc, hbl, vbl, hsync, vsync, de) so downstream blocks can pass timing as one bundle.
- One sub-module, sync_window: generic per-axis counter-in-window compare with modulo offset. It is instantiated twice (H and V); only the width and total differ.

Test Plan:
- Defaults, offsets 0, free-running ce_pix every 4th clk:
  - 384 enables per line, 262 lines per frame.
  - hbl rises at hc=256; hsync is active for hc 264..295.
  - vsync is active for vc 228..231.
  - de is low whenever hc>=256 or vc>=224.
- hs_offset=+100 (window 364..395, wraps to 12):
  - hsync is active for hc>=364 or hc<12, i.e. 32 pixels.
  - hs_offset=-264 gives hsync active for hc 0..31.
- vs_offset changed from 0 to 5 at vc=100:
  - Current frame vsync stays at lines 228..231.
  - Next frame vsync is at lines 233..236.
- Strobes and frame counter:
  - After reset, exactly 262 line_start pulses occur per frame and one frame_start at hc=vc=0.
  - frame_cnt reaches 255 then 0 after 256 frames (FC_W=8).
- ce_pix held low for 50 clks at hc=200: all outputs hold and no strobes fire; counting resumes at hc=201.
- Reset asserted at hc=300, vc=150:
  - Next clk: hc=vc=0, hsync and vsync inactive, frame_cnt=0.
  - Timing re-verified against a reference model for 2 frames with SYNC_POL=0 (sync idle high).

Source files
------------

// File: rtl/video_pkg.sv
// Shared raster-timing definitions: default 6 MHz geometry and a bundled
// timing record for downstream video blocks.
package video_pkg;

  localparam int VID_CW       = 9;
  localparam int VID_H_TOTAL  = 384;
  localparam int VID_H_ACTIVE = 256;
  localparam int VID_HS_START = 264;
  localparam int VID_HS_END   = 296;
  localparam int VID_V_TOTAL  = 262;
  localparam int VID_V_ACTIVE = 224;
  localparam int VID_VS_START = 228;
  localparam int VID_VS_END   = 232;
  localparam int VID_OFS_W    = 9;
  localparam int VID_SYNC_POL = 1;
  localparam int VID_FC_W     = 8;

  // One bundle of timing so tilemap/sprite/palette stages can pipe it along.
  typedef struct packed {
    logic [VID_CW-1:0] hc;
    logic [VID_CW-1:0] vc;
    logic              hbl;
    logic              vbl;
    logic              hsync;
    logic              vsync;
    logic              de;
  } timing_t;

endpackage

// File: rtl/video_timing_gen_sync_window.sv
// Per-axis sync window: shifts a nominal [START, STOP) window by a signed
// offset modulo TOTAL and reports whether the given count lies inside it.
// A window whose shifted start exceeds its end wraps through count 0.
module sync_window
  import video_pkg::*;
#(
  parameter int CW    = VID_CW,
  parameter int OFS_W = VID_OFS_W,
  parameter int TOTAL = VID_H_TOTAL,
  parameter int START = VID_HS_START,
  parameter int STOP  = VID_HS_END
) (
  input  logic [CW-1:0]           count,
  input  logic signed [OFS_W-1:0] offset,
  output logic                    active
);

  // Two guard bits let START+offset go negative or exceed TOTAL without overflow.
  localparam int AW = CW + 2;
  localparam logic signed [AW-1:0] TOTAL_S = AW'(TOTAL);
  localparam logic signed [AW-1:0] START_S = AW'(START);
  localparam logic signed [AW-1:0] STOP_S  = AW'(STOP);

  logic signed [AW-1:0] ofs_ext;
  logic signed [AW-1:0] cnt_ext;
  logic signed [AW-1:0] win_s;
  logic signed [AW-1:0] win_e;

  // Offset magnitude is below TOTAL, so one add or subtract brings it back in range.
  function automatic logic signed [AW-1:0] mod_total(input logic signed [AW-1:0] raw);
    logic signed [AW-1:0] fixed;
    fixed = raw;
    if (raw >= TOTAL_S)
      fixed = raw - TOTAL_S;
    else if (raw < 0)
      fixed = raw + TOTAL_S;
    return fixed;
  endfunction

  assign ofs_ext = AW'(offset);
  assign cnt_ext = signed'({2'b00, count});
  assign win_s   = mod_total(START_S + ofs_ext);
  assign win_e   = mod_total(STOP_S + ofs_ext);

  // Window compare: plain range, wrapped range, or empty when start equals end.
  always_comb begin
    active = 1'b0;
    if (win_s < win_e)
      active = (cnt_ext >= win_s) && (cnt_ext < win_e);
    else if (win_s > win_e)
      active = (cnt_ext >= win_s) || (cnt_ext < win_e);
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator. Counters and every decoded flag are
// registered together from the next-state counter values, so flags always
// match the hc/vc presented alongside them. Sync offsets are shadowed once
// per frame at the (0,0) wrap so sync position never changes mid-frame.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int CW       = VID_CW,
  parameter int H_TOTAL  = VID_H_TOTAL,
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int HS_START = VID_HS_START,
  parameter int HS_END   = VID_HS_END,
  parameter int V_TOTAL  = VID_V_TOTAL,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int VS_START = VID_VS_START,
  parameter int VS_END   = VID_VS_END,
  parameter int OFS_W    = VID_OFS_W,
  parameter int SYNC_POL = VID_SYNC_POL,
  parameter int FC_W     = VID_FC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce_pix,
  input  logic signed [OFS_W-1:0] hs_offset,
  input  logic signed [OFS_W-1:0] vs_offset,
  output logic [CW-1:0]           hc,
  output logic [CW-1:0]           vc,
  output logic                    hbl,
  output logic                    vbl,
  output logic                    de,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [FC_W-1:0]         frame_cnt
);

  localparam logic SYNC_IDLE = (SYNC_POL == 0);

  logic [CW-1:0]           hc_reg, vc_reg;
  logic [CW-1:0]           hc_next, vc_next;
  logic [FC_W-1:0]         frame_cnt_reg;
  logic signed [OFS_W-1:0] hs_sh_reg, vs_sh_reg;
  logic signed [OFS_W-1:0] hs_ofs_eff, vs_ofs_eff;
  logic                    hbl_reg, vbl_reg, de_reg, hsync_reg, vsync_reg;
  logic                    line_start_reg, frame_start_reg;
  logic                    line_end, wrap;
  logic                    hbl_next, vbl_next, h_act, v_act;

  // Next counter values and the frame-origin wrap condition.
  always_comb begin
    line_end = (hc_reg == CW'(H_TOTAL - 1));
    hc_next  = line_end ? '0 : hc_reg + CW'(1);
    vc_next  = vc_reg;
    if (line_end)
      vc_next = (vc_reg == CW'(V_TOTAL - 1)) ? '0 : vc_reg + CW'(1);
    wrap = line_end && (vc_reg == CW'(V_TOTAL - 1));
  end

  // On the wrap cycle the freshly sampled offsets already govern the new frame's (0,0).
  assign hs_ofs_eff = wrap ? hs_offset : hs_sh_reg;
  assign vs_ofs_eff = wrap ? vs_offset : vs_sh_reg;
  assign hbl_next   = (hc_next >= CW'(H_ACTIVE));
  assign vbl_next   = (vc_next >= CW'(V_ACTIVE));

  sync_window #(
    .CW(CW), .OFS_W(OFS_W), .TOTAL(H_TOTAL), .START(HS_START), .STOP(HS_END)
  ) u_hwin (
    .count(hc_next), .offset(hs_ofs_eff), .active(h_act)
  );

  sync_window #(
    .CW(CW), .OFS_W(OFS_W), .TOTAL(V_TOTAL), .START(VS_START), .STOP(VS_END)
  ) u_vwin (
    .count(vc_next), .offset(vs_ofs_eff), .active(v_act)
  );

  // Counter, flag, strobe and shadow state; everything holds while ce_pix is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_reg          <= '0;
      vc_reg          <= '0;
      frame_cnt_reg   <= '0;
      hs_sh_reg       <= '0;
      vs_sh_reg       <= '0;
      hbl_reg         <= 1'b0;
      vbl_reg         <= 1'b0;
      de_reg          <= 1'b1;
      hsync_reg       <= SYNC_IDLE;
      vsync_reg       <= SYNC_IDLE;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (ce_pix) begin
      hc_reg          <= hc_next;
      vc_reg          <= vc_next;
      hbl_reg         <= hbl_next;
      vbl_reg         <= vbl_next;
      de_reg          <= ~hbl_next & ~vbl_next;
      hsync_reg       <= h_act ^ SYNC_IDLE;
      vsync_reg       <= v_act ^ SYNC_IDLE;
      line_start_reg  <= line_end;
      frame_start_reg <= wrap;
      if (wrap) begin
        frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
        hs_sh_reg     <= hs_offset;
        vs_sh_reg     <= vs_offset;
      end
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign hc          = hc_reg;
  assign vc          = vc_reg;
  assign hbl         = hbl_reg;
  assign vbl         = vbl_reg;
  assign de          = de_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (24x14) so many frames fit
// in a short run. Active-low sync and a 3-bit frame counter are used so the
// idle-high sync level and frame counter wrap are both exercised.
module tb_video_timing_gen;

  localparam int CW  = 6;
  localparam int HT  = 24;
  localparam int HA  = 16;
  localparam int HSS = 18;
  localparam int HSE = 21;
  localparam int VT  = 14;
  localparam int VA  = 10;
  localparam int VSS = 11;
  localparam int VSE = 13;
  localparam int OW  = 7;
  localparam int POL = 0;
  localparam int FCW = 3;

  logic                 clk;
  logic                 reset;
  logic                 ce_pix;
  logic signed [OW-1:0] hs_offset;
  logic signed [OW-1:0] vs_offset;
  logic [CW-1:0]        hc, vc;
  logic                 hbl, vbl, de, hsync, vsync, line_start, frame_start;
  logic [FCW-1:0]       frame_cnt;

  video_timing_gen #(
    .CW(CW), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE),
    .OFS_W(OW), .SYNC_POL(POL), .FC_W(FCW)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hs_offset(hs_offset), .vs_offset(vs_offset),
    .hc(hc), .vc(vc), .hbl(hbl), .vbl(vbl), .de(de),
    .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hc, vc, hbl, vbl, de, hs, vs, ls, fs, fc;
  } exp_t;

  exp_t sb[$];
  exp_t m_out;
  int   m_hc, m_vc, m_fc, m_hsh, m_vsh;
  int   hs_in, vs_in;
  int   checks = 0;
  int   failures = 0;
  int   ls_cnt = 0;
  int   en_cnt = 0;

  // Membership by distance from window start: inside when (cnt-s) mod tot < (e-s) mod tot.
  function automatic int in_win(int cnt, int st, int sp, int ofs, int tot);
    int s, e, len, d;
    s   = ((st + ofs) % tot + tot) % tot;
    e   = ((sp + ofs) % tot + tot) % tot;
    len = ((e - s) % tot + tot) % tot;
    d   = ((cnt - s) % tot + tot) % tot;
    return (d < len) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (model hc=%0d vc=%0d)", tag, obs, exp, m_hc, m_vc);
    end
  endtask

  // One clock: drive inputs, push the model's expectation, then pop and compare after the edge.
  task automatic tick(input logic ce, input logic rst);
    exp_t e, got;
    int   nhc, nvc, idle;
    @(negedge clk);
    ce_pix    = ce;
    reset     = rst;
    hs_offset = OW'(hs_in);
    vs_offset = OW'(vs_in);
    idle      = (POL == 0) ? 1 : 0;
    e         = m_out;
    e.ls      = 0;
    e.fs      = 0;
    if (rst) begin
      m_hc = 0; m_vc = 0; m_fc = 0; m_hsh = 0; m_vsh = 0;
      e.hc = 0; e.vc = 0; e.fc = 0;
      e.hbl = 0; e.vbl = 0; e.de = 1; e.hs = idle; e.vs = idle;
    end else if (ce) begin
      nhc = (m_hc == HT - 1) ? 0 : m_hc + 1;
      nvc = m_vc;
      if (m_hc == HT - 1) nvc = (m_vc == VT - 1) ? 0 : m_vc + 1;
      e.ls = (nhc == 0) ? 1 : 0;
      if (nhc == 0 && nvc == 0) begin
        e.fs  = 1;
        m_fc  = (m_fc + 1) % (1 << FCW);
        m_hsh = hs_in;
        m_vsh = vs_in;
      end
      m_hc  = nhc;
      m_vc  = nvc;
      e.hc  = nhc;
      e.vc  = nvc;
      e.fc  = m_fc;
      e.hbl = (nhc >= HA) ? 1 : 0;
      e.vbl = (nvc >= VA) ? 1 : 0;
      e.de  = (e.hbl == 0 && e.vbl == 0) ? 1 : 0;
      e.hs  = in_win(nhc, HSS, HSE, m_hsh, HT) ^ idle;
      e.vs  = in_win(nvc, VSS, VSE, m_vsh, VT) ^ idle;
    end
    m_out = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("hc", 32'(hc), 32'(got.hc));
    check("vc", 32'(vc), 32'(got.vc));
    check("hbl", 32'(hbl), 32'(got.hbl));
    check("vbl", 32'(vbl), 32'(got.vbl));
    check("de", 32'(de), 32'(got.de));
    check("hsync", 32'(hsync), 32'(got.hs));
    check("vsync", 32'(vsync), 32'(got.vs));
    check("line_start", 32'(line_start), 32'(got.ls));
    check("frame_start", 32'(frame_start), 32'(got.fs));
    check("frame_cnt", 32'(frame_cnt), 32'(got.fc));
    // Period accounting independent of the per-pixel model.
    if (rst) begin
      ls_cnt = 0;
      en_cnt = 0;
    end else begin
      if (ce) en_cnt++;
      if (line_start === 1'b1) ls_cnt++;
      if (frame_start === 1'b1) begin
        check("lines_per_frame", 32'(ls_cnt), 32'(VT));
        check("enables_per_frame", 32'(en_cnt), 32'(HT * VT));
        ls_cnt = 0;
        en_cnt = 0;
      end
    end
  endtask

  task automatic run_en(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0);
      for (int j = 0; j < gap; j++) tick(1'b0, 1'b0);
    end
  endtask

  task automatic run_to(input int h, input int v);
    int guard;
    guard = 0;
    while (!(m_hc == h && m_vc == v) && guard < 2 * HT * VT) begin
      tick(1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (!(m_hc == h && m_vc == v)) begin
      failures++;
      $display("FAIL run_to observed=%0d,%0d expected=%0d,%0d", m_hc, m_vc, h, v);
    end
  endtask

  initial begin
    reset     = 1'b1;
    ce_pix    = 1'b0;
    hs_offset = '0;
    vs_offset = '0;
    hs_in     = 0;
    vs_in     = 0;
    m_out     = '{default: 0};
    m_hc = 0; m_vc = 0; m_fc = 0; m_hsh = 0; m_vsh = 0;

    // Reset (also with ce_pix high, reset must win).
    repeat (3) tick(1'b1, 1'b1);
    // Nominal offsets, enable every 4th clock, a little past one frame.
    run_en(HT * VT + 5, 3);
    // Forward hsync shift whose window wraps through pixel 0.
    hs_in = 4;
    run_en(2 * HT * VT, 0);
    // Backward shift landing exactly at pixel 0, then one needing the add-total fix.
    hs_in = -18;
    run_en(2 * HT * VT, 0);
    hs_in = -20;
    run_en(2 * HT * VT, 0);
    // Mid-frame vsync offset change must wait for the next frame.
    hs_in = 0;
    run_to(0, 5);
    vs_in = 1;
    run_en(2 * HT * VT, 0);
    // Vertical window wrapping through line 0.
    vs_in = -12;
    run_en(2 * HT * VT, 0);
    // Enough frames to wrap the 3-bit frame counter.
    vs_in = 0;
    run_en(9 * HT * VT, 0);
    // Pixel clock stalled mid-line: everything holds, no strobes.
    run_to(14, 3);
    repeat (50) tick(1'b0, 1'b0);
    run_en(2 * HT, 0);
    // Reset mid-frame, then two full frames.
    run_to(20, 8);
    tick(1'b1, 1'b1);
    run_en(2 * HT * VT + 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
